// File: rtl/oled_pkg.sv
// Shared types and defaults for the OLED character arbiter.
// The CLEAR state exists only when OLED_ARB_CLEAR_EN is defined.
package oled_pkg;

    localparam logic [6:0] BLANK_CHAR_DEFAULT   = 7'h20;
    localparam int         SCREEN_CHARS_DEFAULT = 64;

`ifdef OLED_ARB_CLEAR_EN
    typedef enum logic [1:0] {IDLE, SEND, GAP, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`endif

    // Screen position after one completed character, wrapping at the screen end.
    function automatic logic [5:0] next_pos(input logic [5:0] pos, input int chars);
        return (pos == 6'(chars - 1)) ? 6'd0 : pos + 6'd1;
    endfunction

endpackage

// File: rtl/oled_char_arbiter_if.sv
// Requester and OLED-controller handshake bundle of the character arbiter.
// The arbiter uses the slave modport; the requesters/controller side uses master.
interface oled_char_arbiter_if;

    logic [6:0] req0_char;
    logic       req0_valid;
    logic       req0_ready;
    logic [6:0] req1_char;
    logic       req1_valid;
    logic       req1_ready;
    logic [6:0] send_data;
    logic       send_data_valid;
    logic       send_done;

    modport slave (
        input  req0_char, req0_valid, req1_char, req1_valid, send_done,
        output req0_ready, req1_ready, send_data, send_data_valid
    );

    modport master (
        output req0_char, req0_valid, req1_char, req1_valid, send_done,
        input  req0_ready, req1_ready, send_data, send_data_valid
    );

endinterface

// File: rtl/oled_rr_arbiter.sv
// Two-way round-robin grant: on a tie the requester that was not granted last wins.
module oled_rr_arbiter (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/oled_char_arbiter.sv
// Arbitrates two character sources onto one OLED controller with registered outputs.
// Define OLED_ARB_CLEAR_EN to blank the whole screen after every reset release.
module oled_char_arbiter
    import oled_pkg::*;
#(
    parameter logic [6:0] BLANK_CHAR   = BLANK_CHAR_DEFAULT,
    parameter int         SCREEN_CHARS = SCREEN_CHARS_DEFAULT
) (
    input  logic                clock,
    input  logic                reset_n,
    oled_char_arbiter_if.slave  bus,
    output logic [5:0]          char_pos,
    output logic                busy,
    output logic                last_grant
);

    state_t     state, state_next;
    logic [6:0] data_next;
    logic       valid_next;
    logic       ready0_next;
    logic       ready1_next;
    logic       last_next;
    logic       busy_next;
    logic [5:0] pos_next;
    logic [1:0] grant;

    oled_rr_arbiter u_rr (
        .req        ({bus.req1_valid, bus.req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

`ifdef OLED_ARB_CLEAR_EN
    logic [6:0] clear_left, clear_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clear_left <= 7'(SCREEN_CHARS);
        end else begin
            clear_left <= clear_next;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            bus.send_data       <= 7'd0;
            bus.send_data_valid <= 1'b0;
            bus.req0_ready      <= 1'b0;
            bus.req1_ready      <= 1'b0;
            char_pos            <= 6'd0;
            busy                <= 1'b0;
            last_grant          <= 1'b1;
        end else begin
            state               <= state_next;
            bus.send_data       <= data_next;
            bus.send_data_valid <= valid_next;
            bus.req0_ready      <= ready0_next;
            bus.req1_ready      <= ready1_next;
            char_pos            <= pos_next;
            busy                <= busy_next;
            last_grant          <= last_next;
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_next  = state;
        data_next   = bus.send_data;
        valid_next  = bus.send_data_valid;
        ready0_next = 1'b0;
        ready1_next = 1'b0;
        pos_next    = char_pos;
        last_next   = last_grant;
`ifdef OLED_ARB_CLEAR_EN
        clear_next  = clear_left;
`endif
        case (state)
            IDLE: begin
`ifdef OLED_ARB_CLEAR_EN
                if (clear_left != 7'd0) begin
                    state_next = CLEAR;
                    data_next  = BLANK_CHAR;
                    valid_next = 1'b1;
                end else
`endif
                if (grant[0]) begin
                    state_next  = SEND;
                    data_next   = bus.req0_char;
                    valid_next  = 1'b1;
                    ready0_next = 1'b1;
                    last_next   = 1'b0;
                end else if (grant[1]) begin
                    state_next  = SEND;
                    data_next   = bus.req1_char;
                    valid_next  = 1'b1;
                    ready1_next = 1'b1;
                    last_next   = 1'b1;
                end
            end
            SEND: begin
                if (bus.send_done) begin
                    state_next = GAP;
                    valid_next = 1'b0;
                    pos_next   = next_pos(char_pos, SCREEN_CHARS);
                end
            end
`ifdef OLED_ARB_CLEAR_EN
            CLEAR: begin
                if (bus.send_done) begin
                    state_next = GAP;
                    valid_next = 1'b0;
                    pos_next   = next_pos(char_pos, SCREEN_CHARS);
                    clear_next = clear_left - 7'd1;
                end
            end
`endif
            GAP: begin
                // Valid stays low for this one cycle so the controller sees a fresh request.
`ifdef OLED_ARB_CLEAR_EN
                if (clear_left != 7'd0) begin
                    state_next = CLEAR;
                    data_next  = BLANK_CHAR;
                    valid_next = 1'b1;
                end else
`endif
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

endmodule

// File: doc/oled_char_arbiter.md
OLED_CHAR_ARBITER -- requirements
Module: oled_char_arbiter

Interface
REQ-001 SHALL have parameter BLANK_CHAR, default 7'h20, character code sent during screen clear.
REQ-002 SHALL have parameter SCREEN_CHARS, default 64, characters per screen (4 pages x 16 chars).
REQ-003 SHALL have port clock  input  1  system clock, 100 MHz, rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req0_char  input  7  requester 0 character code.
REQ-006 SHALL have port req0_valid  input  1  requester 0 holds the character until accepted.
REQ-007 SHALL have port req0_ready  output  1  one-cycle pulse: requester 0 character accepted.
REQ-008 SHALL have ports req1_char, req1_valid and req1_ready, identical to requester 0.
REQ-009 SHALL have port send_data  output  7  character code to the OLED controller.
REQ-010 SHALL have port send_data_valid  output  1  character request to the OLED controller.
REQ-011 SHALL have port send_done  input  1  one-cycle pulse from the OLED controller when the 8 column bytes are sent.
REQ-012 SHALL have port char_pos  output  6  screen position of the next character, 0..SCREEN_CHARS-1.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port last_grant  output  1  index of the most recently granted requester.

Function
REQ-015 SHALL use the FSM states IDLE, SEND, GAP and CLEAR; all outputs SHALL be registered.
REQ-016 In IDLE, if either reqN_valid is high, the block SHALL latch that requester's char into send_data, pulse reqN_ready for one cycle, and enter SEND on the next edge.
REQ-017 When both requesters are valid, the requester not equal to last_grant SHALL win (round-robin); last_grant SHALL update on every grant.
REQ-018 Latency: valid sampled in IDLE in cycle N SHALL produce reqN_ready=1 and send_data_valid=1 in cycle N+1.
REQ-019 In SEND, send_data_valid SHALL stay at 1 and send_data SHALL stay stable until send_done is sampled high.
REQ-020 When send_done is sampled high, the block SHALL go to GAP with send_data_valid=0; GAP SHALL last exactly one cycle and then return to IDLE. This guarantees the controller sees valid low before the next request.
REQ-021 char_pos SHALL increment once per completed character, leaving SEND; it SHALL wrap from SCREEN_CHARS-1 to 0.
REQ-022 A send_done pulse outside SEND and CLEAR SHALL be ignored.
REQ-023 Requests arriving while busy SHALL be held off: reqN_ready stays 0 until the block returns to IDLE.
REQ-024 reqN_ready SHALL never be high for both requesters in the same cycle.

Reset
REQ-025 reset_n low SHALL immediately force IDLE, send_data=0, send_data_valid=0, req0_ready=0, req1_ready=0, char_pos=0, busy=0 and last_grant=1 (so requester 0 wins the first tie).
REQ-026 Asserting reset_n mid-SEND SHALL abandon the character without any ready re-pulse; after release, the block SHALL behave as from power-up.

Configuration
REQ-027 With OLED_ARB_CLEAR_EN defined, the block SHALL enter CLEAR after reset release and send SCREEN_CHARS copies of BLANK_CHAR using the same SEND/GAP handshake.
REQ-028 During CLEAR, reqN_ready SHALL stay 0 and busy=1; char_pos SHALL count up and wrap to 0; the block SHALL then enter IDLE.
REQ-029 Without OLED_ARB_CLEAR_EN, the CLEAR state and its counter SHALL not be compiled, and reset release SHALL lead directly to IDLE.

Structure
REQ-030 The shared package oled_pkg SHALL hold the FSM state type, the BLANK_CHAR default and the SCREEN_CHARS default.
REQ-031 The round-robin grant SHALL be implemented in the sub-module oled_rr_arbiter (2 requests, last_grant in, one-hot grant out).

Verification
REQ-032 Single request: req0_valid=1 with char 7'h41 -> req0_ready pulse and send_data=7'h41 with valid=1 one cycle later; send_done -> valid=0 next cycle; char_pos=1.
REQ-033 Tie: both valid from reset, 4 characters -> grants in the order 0,1,0,1; last_grant ends at 1.
REQ-034 Wrap: 64 characters completed -> char_pos goes 63 -> 0.
REQ-035 Held off: req1_valid rises during SEND -> req1_ready stays 0 until two cycles after send_done.
REQ-036 Reset mid-SEND: reset_n low for 3 cycles -> all outputs at reset values immediately; no ready pulse follows.
REQ-037 With OLED_ARB_CLEAR_EN: after reset, 64 transfers of 7'h20 with requests ignored; then a req0 character is accepted.
